// File: rtl/q44_div_pkg.sv
// Shared types and Q4.4 constants for the shared divider arbiter.
// State encoding plus fixed-point reference values.
package q44_div_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP,
    S_DRAIN
  } state_t;

  localparam logic [7:0] Q44_ZERO = 8'h00;
  localparam logic [7:0] Q44_ONE  = 8'h10;
  localparam logic [7:0] Q44_MAX  = 8'h7F;
  localparam logic [7:0] Q44_MIN  = 8'h80;

endpackage

// File: rtl/q44_div_arbiter_rr.sv
// Rotating-priority encoder: first request after the last winner.
// Purely combinational; wraps from N-1 back to 0.
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic [N-1:0] gnt_onehot,
  output logic [W-1:0] gnt_idx
);

  // search last+1, last+2, ... with wrap, first hit wins
  always_comb begin
    logic found;
    int   idx;
    gnt_onehot = '0;
    gnt_idx    = '0;
    found      = 1'b0;
    idx        = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last) + k) % N;
      if (!found && req[idx]) begin
        found           = 1'b1;
        gnt_onehot[idx] = 1'b1;
        gnt_idx         = W'(idx);
      end
    end
  end

endmodule

// File: rtl/q44_div_arbiter.sv
// Round-robin front end sharing one Q4.4 divider among requesters.
// Watchdog turns a hung divider into an error response.
module q44_div_arbiter
  import q44_div_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int TIMEOUT = 31,
  localparam int GW      = $clog2(N_REQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_num,
  input  logic [8*N_REQ-1:0] req_den,
  output logic [N_REQ-1:0]   req_ready,
  output logic [N_REQ-1:0]   rsp_valid,
  output logic [7:0]         rsp_quot,
  output logic               rsp_err,
  output logic               div_start,
  output logic [7:0]         div_num,
  output logic [7:0]         div_den,
  input  logic [7:0]         div_quot,
  input  logic               div_valid,
  input  logic               div_error,
  output logic               busy,
  output logic [GW-1:0]      grant_id
);

  localparam logic [7:0] TO_MAX = 8'(TIMEOUT);

  state_t           state;
  state_t           nstate;
  logic [GW-1:0]    last_grant;
  logic [7:0]       wdog;
  logic             to_flag;
  logic [N_REQ-1:0] gnt;
  logic [GW-1:0]    gidx;

  rr_arbiter #(.N(N_REQ)) u_arb (
    .req        (req_valid),
    .last       (last_grant),
    .gnt_onehot (gnt),
    .gnt_idx    (gidx)
  );

  assign busy = (state != S_IDLE);

  // next state, handshake strobes and response routing
  always_comb begin
    nstate    = state;
    req_ready = '0;
    rsp_valid = '0;
    div_start = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (|req_valid) begin
          req_ready = gnt;
          nstate    = S_ISSUE;
        end
      end
      S_ISSUE: begin
        div_start = 1'b1;
        nstate    = S_WAIT;
      end
      S_WAIT: begin
        if (div_valid || wdog == TO_MAX)
          nstate = S_RESP;
      end
      S_RESP: begin
        rsp_valid[grant_id] = 1'b1;
        nstate = to_flag ? S_DRAIN : S_IDLE;
      end
      S_DRAIN: begin
        if (div_valid)
          nstate = S_IDLE;
      end
      default: nstate = S_IDLE;
    endcase
  end

  // state, operand latch, watchdog and result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= GW'(N_REQ - 1);
      grant_id   <= '0;
      div_num    <= '0;
      div_den    <= '0;
      wdog       <= '0;
      to_flag    <= 1'b0;
      rsp_quot   <= '0;
      rsp_err    <= 1'b0;
    end else begin
      state <= nstate;
      unique case (state)
        S_IDLE: begin
          if (|req_valid) begin
            last_grant <= gidx;
            grant_id   <= gidx;
            div_num    <= req_num[{gidx, 3'b000} +: 8];
            div_den    <= req_den[{gidx, 3'b000} +: 8];
          end
        end
        S_ISSUE: begin
          wdog    <= '0;
          to_flag <= 1'b0;
        end
        S_WAIT: begin
          wdog <= wdog + 8'd1;
          if (div_valid) begin
            rsp_quot <= div_quot;
            rsp_err  <= div_error;
          end else if (wdog == TO_MAX) begin
            rsp_quot <= Q44_ZERO;
            rsp_err  <= 1'b1;
            to_flag  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_q44_div_arbiter.sv
// Bench for q44_div_arbiter with a latency-programmable divider stub.
// Event-level reference model checks grants, timing and responses.
module tb_q44_div_arbiter;

  localparam int N  = 4;
  localparam int GW = 2;
  localparam int TO = 31;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic [N-1:0]   req_valid;
  logic [8*N-1:0] req_num;
  logic [8*N-1:0] req_den;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [7:0]     rsp_quot;
  logic           rsp_err;
  logic           div_start;
  logic [7:0]     div_num;
  logic [7:0]     div_den;
  logic [7:0]     div_quot;
  logic           div_valid;
  logic           div_error;
  logic           busy;
  logic [GW-1:0]  grant_id;

  always #5 clk = ~clk;

  q44_div_arbiter #(.N_REQ(N), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_num   (req_num),
    .req_den   (req_den),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_quot  (rsp_quot),
    .rsp_err   (rsp_err),
    .div_start (div_start),
    .div_num   (div_num),
    .div_den   (div_den),
    .div_quot  (div_quot),
    .div_valid (div_valid),
    .div_error (div_error),
    .busy      (busy),
    .grant_id  (grant_id)
  );

  // Q4.4 signed divide: truncate toward zero, saturate, 0 on den==0
  function automatic logic [7:0] ref_q(logic [7:0] n, logic [7:0] d);
    int a;
    int b;
    int q;
    if (d == 8'h00) return 8'h00;
    a = int'($signed(n));
    b = int'($signed(d));
    q = (a * 16) / b;
    if (q > 127)  q = 127;
    if (q < -128) q = -128;
    return q[7:0];
  endfunction

  // divider stub: result lat+1 cycles after start, or never while hang
  int         lat = 2;
  bit         hang = 1'b0;
  logic       s_pend;
  int         s_cnt;
  logic [7:0] s_n;
  logic [7:0] s_d;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_valid <= 1'b0;
      div_quot  <= 8'h00;
      div_error <= 1'b0;
      s_pend    <= 1'b0;
      s_cnt     <= 0;
      s_n       <= 8'h00;
      s_d       <= 8'h00;
    end else begin
      div_valid <= 1'b0;
      if (div_start) begin
        s_pend <= 1'b1;
        s_cnt  <= lat;
        s_n    <= div_num;
        s_d    <= div_den;
      end else if (s_pend && !hang) begin
        if (s_cnt <= 1) begin
          s_pend    <= 1'b0;
          div_valid <= 1'b1;
          div_quot  <= ref_q(s_n, s_d);
          div_error <= (s_d == 8'h00);
        end else begin
          s_cnt <= s_cnt - 1;
        end
      end
    end
  end

  int         n_cmp;
  int         n_bad;
  int         cyc;
  bit [N-1:0] pend;
  logic [7:0] na [N];
  logic [7:0] da [N];
  int         last;
  bit         outst;
  bit         drain;
  bit         to;
  int         hs_cyc;
  int         hs_id;
  logic [7:0] hs_n;
  logic [7:0] hs_d;
  int         exp_cyc;
  logic [7:0] exp_q;
  bit         exp_e;
  int         grants [$];
  int         r_id;
  int         r_cyc;
  logic [7:0] r_q;
  logic       r_e;
  int         rsp_cnt;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: got %0h want %0h", nm, cyc, act, exp);
    end
  endtask

  task automatic apply();
    req_valid = pend;
    for (int i = 0; i < N; i++) begin
      req_num[8*i +: 8] = na[i];
      req_den[8*i +: 8] = da[i];
    end
  endtask

  // one clock: observe at negedge, update model, drive after posedge
  task automatic step();
    logic [N-1:0] er;
    logic [N-1:0] ev;
    int           w;
    @(negedge clk);
    cyc++;
    if (!rst_n) begin
      chk("rst_out", {req_ready, rsp_valid, rsp_quot, rsp_err, div_start,
                      busy, grant_id, div_num, div_den}, 64'd0);
      last    = N - 1;
      outst   = 1'b0;
      drain   = 1'b0;
      exp_cyc = -1;
    end else begin
      er = '0;
      w  = -1;
      if (!outst && !drain && req_valid != 0) begin
        for (int k = N; k >= 1; k--)
          if (req_valid[(last + k) % N]) w = (last + k) % N;
        er[w] = 1'b1;
      end
      chk("busy", busy, outst || drain);
      if (req_valid != 0 || req_ready != 0)
        chk("req_ready", req_ready, er);
      chk("div_start", div_start, outst && cyc == hs_cyc + 1);
      if (outst && cyc == hs_cyc + 1) begin
        chk("div_num", div_num, hs_n);
        chk("div_den", div_den, hs_d);
      end
      if (drain && div_valid) drain = 1'b0;
      ev = '0;
      if (outst && cyc == exp_cyc) ev[hs_id] = 1'b1;
      if (rsp_valid != 0 || ev != 0) begin
        chk("rsp_valid", rsp_valid, ev);
        if (ev != 0) begin
          chk("rsp_quot", rsp_quot, exp_q);
          chk("rsp_err", rsp_err, exp_e);
          chk("grant_id", grant_id, hs_id);
          r_id  = hs_id;
          r_cyc = cyc;
          r_q   = rsp_quot;
          r_e   = rsp_err;
          rsp_cnt++;
          outst = 1'b0;
          drain = to;
        end
      end
      if (outst && exp_cyc < 0) begin
        if (div_valid && cyc >= hs_cyc + 2) begin
          exp_cyc = cyc + 1;
          exp_q   = ref_q(hs_n, hs_d);
          exp_e   = (hs_d == 8'h00);
          to      = 1'b0;
        end else if (cyc == hs_cyc + 2 + TO) begin
          exp_cyc = cyc + 1;
          exp_q   = 8'h00;
          exp_e   = 1'b1;
          to      = 1'b1;
        end
      end
      if (er != 0 && req_ready == er) begin
        last    = w;
        outst   = 1'b1;
        hs_cyc  = cyc;
        hs_id   = w;
        hs_n    = na[w];
        hs_d    = da[w];
        exp_cyc = -1;
        pend[w] = 1'b0;
        grants.push_back(w);
      end
    end
    @(posedge clk);
    #1;
    apply();
  endtask

  task automatic wait_rsp(input int target, input int bound, input string nm);
    int n;
    n = 0;
    while (rsp_cnt < target && n < bound) begin
      step();
      n++;
    end
    chk({nm, "_rsp_seen"}, rsp_cnt >= target, 1'b1);
  endtask

  task automatic settle(input int bound, input string nm);
    int n;
    n = 0;
    while ((pend != 0 || outst || drain) && n < bound) begin
      step();
      n++;
    end
    chk({nm, "_settled"}, (pend != 0) || outst || drain, 1'b0);
  endtask

  task automatic do_reset();
    pend  = '0;
    apply();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  typedef struct {
    int         id;
    logic [7:0] n;
    logic [7:0] d;
    logic [7:0] q;
    logic       e;
  } vec_t;

  vec_t vt [6];
  int   c0;
  int   g0;

  initial begin
    vt[0] = '{0, 8'h20, 8'h10, 8'h20, 1'b0};
    vt[1] = '{2, 8'h30, 8'h00, 8'h00, 1'b1};
    vt[2] = '{1, 8'hE0, 8'h20, 8'hF0, 1'b0};
    vt[3] = '{3, 8'h10, 8'h40, 8'h04, 1'b0};
    vt[4] = '{0, 8'h7F, 8'h08, 8'h7F, 1'b0};
    vt[5] = '{1, 8'h80, 8'hF0, 8'h7F, 1'b0};

    n_cmp = 0; n_bad = 0; cyc = 0; rsp_cnt = 0;
    last = N - 1; outst = 0; drain = 0; to = 0;
    hs_cyc = -10; hs_id = 0; exp_cyc = -1;
    for (int i = 0; i < N; i++) begin na[i] = 8'h00; da[i] = 8'h00; end
    pend = '0;
    apply();
    repeat (3) step();
    rst_n = 1'b1;
    step();

    // single operations from the vector table
    for (int i = 0; i < 6; i++) begin
      na[vt[i].id]   = vt[i].n;
      da[vt[i].id]   = vt[i].d;
      pend[vt[i].id] = 1'b1;
      apply();
      c0 = rsp_cnt;
      wait_rsp(c0 + 1, 80, $sformatf("vec%0d", i));
      chk($sformatf("vec%0d_id", i), r_id, vt[i].id);
      chk($sformatf("vec%0d_q", i), r_q, vt[i].q);
      chk($sformatf("vec%0d_e", i), r_e, vt[i].e);
      chk($sformatf("vec%0d_lat", i), r_cyc - hs_cyc, lat + 3);
    end

    // all four after reset, then req0+req3
    do_reset();
    grants.delete();
    for (int i = 0; i < N; i++) begin
      na[i] = 8'(8'h10 * (i + 1));
      da[i] = 8'h10;
    end
    pend = 4'b1111;
    apply();
    settle(200, "rr4");
    pend = 4'b1001;
    apply();
    settle(100, "rr2");
    chk("rr_count", grants.size(), 6);
    if (grants.size() == 6) begin
      chk("rr_g0", grants[0], 0);
      chk("rr_g1", grants[1], 1);
      chk("rr_g2", grants[2], 2);
      chk("rr_g3", grants[3], 3);
      chk("rr_g4", grants[4], 0);
      chk("rr_g5", grants[5], 3);
    end

    // hung divider: watchdog error, then drain blocks grants
    hang = 1'b1;
    c0 = rsp_cnt;
    na[1] = 8'h40; da[1] = 8'h20;
    pend[1] = 1'b1;
    apply();
    wait_rsp(c0 + 1, 100, "wdog");
    chk("wdog_err", r_e, 1'b1);
    chk("wdog_q", r_q, 8'h00);
    chk("wdog_lat", r_cyc - hs_cyc, TO + 3);
    g0 = grants.size();
    pend[2] = 1'b1;
    pend[0] = 1'b1;
    apply();
    repeat (10) step();
    chk("drain_nogrant", grants.size(), g0);
    chk("drain_busy", busy, 1'b1);
    hang = 1'b0;
    settle(100, "drain");
    chk("drain_rsp_cnt", rsp_cnt, c0 + 3);
    if (grants.size() == g0 + 2) begin
      chk("drain_g0", grants[g0], 2);
      chk("drain_g1", grants[g0 + 1], 0);
    end else begin
      chk("drain_gcount", grants.size(), g0 + 2);
    end

    // div_valid on the timeout cycle wins over the watchdog
    lat = TO;
    c0 = rsp_cnt;
    na[3] = 8'h20; da[3] = 8'h10;
    pend[3] = 1'b1;
    apply();
    wait_rsp(c0 + 1, 100, "prio");
    chk("prio_err", r_e, 1'b0);
    chk("prio_q", r_q, 8'h20);
    chk("prio_lat", r_cyc - hs_cyc, TO + 3);
    lat = 2;
    pend[0] = 1'b1;
    apply();
    step();
    chk("prio_nodrain", hs_cyc - r_cyc, 1);
    settle(100, "prio");

    // async reset mid-WAIT, then req0 wins over req3
    lat = 10;
    na[1] = 8'h30; da[1] = 8'h10;
    pend[1] = 1'b1;
    apply();
    repeat (6) step();
    chk("mid_busy", busy, 1'b1);
    rst_n = 1'b0;
    step();
    chk("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    lat = 2;
    g0 = grants.size();
    na[0] = 8'h10; da[0] = 8'h10;
    na[3] = 8'h20; da[3] = 8'h10;
    pend = 4'b1001;
    apply();
    settle(100, "rst");
    if (grants.size() == g0 + 2) begin
      chk("rst_g0", grants[g0], 0);
      chk("rst_g1", grants[g0 + 1], 3);
    end else begin
      chk("rst_gcount", grants.size(), g0 + 2);
    end

    // randomized traffic against the reference model
    for (int t = 0; t < 600; t++) begin
      if ($urandom_range(0, 49) == 0) lat = $urandom_range(1, 6);
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) == 0) begin
          pend[i] = 1'b1;
          na[i]   = 8'($urandom);
          da[i]   = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        end else if (pend[i] && $urandom_range(0, 40) == 0) begin
          pend[i] = 1'b0;
        end
      end
      apply();
      step();
    end
    settle(300, "rand");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
